compress_ctrl: RTL and testbench

Sequences one Kyber polynomial (256 coefficients, 8 per 96-bit beat, 32 beats) from the coefficient RAM through the `compress` unit at the selected d (1, 4 or 10). It packs the compressed fields into a 32-bit little-endian word stream with valid/ready flow control. It sits between the polynomial RAM and the ciphertext output buffer, and owns the compress unit's `d` input.

---
 rtl/compress_ctrl_if.sv | 10 +
 rtl/compress_ctrl.sv | 108 ++++++++++
 tb/tb_compress_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/compress_ctrl_if.sv
// compress_ctrl_if: packed 32-bit word stream from compress_ctrl to the ciphertext buffer
//   out_valid/out_data/out_last driven by the master, out_ready by the slave.
interface compress_ctrl_if;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [31:0] out_data;
  modport master (output out_valid, out_data, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/compress_ctrl.sv
// compress_ctrl: streams one Kyber polynomial from RAM through compress and packs it into 32-bit words
//   ports: clk, rst_n (async active-low), start/d_sel/base_addr request, busy/done/err status,
//          rd_en/rd_addr RAM reads, cmp_d plus cmp_d1/d4/d10_in compress unit, ostr packed word stream.
//   COMPRESS_CTRL_STALL_CNT_EN adds stall_cnt, counting backpressured cycles while busy.
module compress_ctrl #(
  parameter int ADDR_W = 5,
  parameter int NBEATS = 32,
  parameter int PK_W   = 192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        d_sel,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        cmp_d,
  input  logic [7:0]        cmp_d1_in,
  input  logic [31:0]       cmp_d4_in,
  input  logic [79:0]       cmp_d10_in,
`ifdef COMPRESS_CTRL_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  compress_ctrl_if.master   ostr
);
  localparam int FW = $clog2(PK_W + 1);
  localparam int IW = $clog2(NBEATS + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t            state, state_nx;
  logic              legal, accept, cap, pop, valid, last;
  logic [ADDR_W-1:0] base_q;
  logic [IW-1:0]     idx;
  logic [1:0]        vld;
  logic [FW-1:0]     fill, fill_nx, off;
  logic [PK_W-1:0]   pk, pk_sh, pk_nx;
  logic [6:0]        nwords, w, total;
  logic [79:0]       cap_data;
  logic [9:0]        need;
  assign legal    = d_sel == 4'd1 || d_sel == 4'd4 || d_sel == 4'd10;
  assign accept   = state == IDLE && start && legal;
  assign w        = cmp_d == 4'd1 ? 7'd8 : cmp_d == 4'd4 ? 7'd32 : 7'd80;
  assign total    = cmp_d == 4'd1 ? 7'd8 : cmp_d == 4'd4 ? 7'd32 : 7'd80;
  assign cap_data = cmp_d == 4'd1 ? {72'b0, cmp_d1_in} : cmp_d == 4'd4 ? {48'b0, cmp_d4_in} : cmp_d10_in;
  // a new read only goes out if the packer can still hold it behind everything already in flight
  assign need     = 10'(fill) + 10'(w) * (10'(vld[0]) + 10'(vld[1]) + 10'd1);
  assign rd_addr  = base_q + idx[ADDR_W-1:0];
  assign cap      = vld[1];
  assign valid    = fill >= FW'(32);
  assign last     = valid && nwords == total - 7'd1;
  assign pop      = valid && ostr.out_ready;
  assign ostr.out_valid = valid;
  assign ostr.out_last  = last;
  assign ostr.out_data  = valid ? pk[31:0] : 32'b0;
  // capture lands above the fill that remains after a same-cycle pop
  assign pk_sh   = pop ? pk >> 32 : pk;
  assign off     = pop ? fill - FW'(32) : fill;
  assign pk_nx   = cap ? pk_sh | ({{(PK_W-80){1'b0}}, cap_data} << off) : pk_sh;
  assign fill_nx = fill + (cap ? FW'(w) : FW'(0)) - (pop ? FW'(32) : FW'(0));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE  ? (accept ? RUN : IDLE) :
               state == RUN   ? (rd_en && idx == IW'(NBEATS - 1) ? DRAIN : RUN) :
               state == DRAIN ? (pop && last ? DONE : DRAIN) : IDLE;
  always_comb begin
    busy  = state == RUN || state == DRAIN;
    done  = state == DONE;
    rd_en = state == RUN && need <= 10'(PK_W);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld    <= '0;
      err    <= 1'b0;
      base_q <= '0;
      cmp_d  <= '0;
      idx    <= '0;
      nwords <= '0;
      pk     <= '0;
      fill   <= '0;
    end else begin
      vld <= {vld[0], rd_en};
      err <= state == IDLE && start && !legal;
      if (accept) begin
        base_q <= base_addr;
        cmp_d  <= d_sel;
        idx    <= '0;
        nwords <= '0;
        pk     <= '0;
        fill   <= '0;
      end else begin
        if (rd_en) idx <= idx + IW'(1);
        if (pop) nwords <= nwords + 7'd1;
        if (state == DONE) cmp_d <= '0;
        pk   <= pk_nx;
        fill <= fill_nx;
      end
    end
`ifdef COMPRESS_CTRL_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (accept) stall_cnt <= '0;
    else if (busy && valid && !ostr.out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_compress_ctrl.sv
// tb_compress_ctrl: table-driven checks of compress_ctrl plus reset and start-while-busy sequences
module tb_compress_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start, busy, done, err, rd_en;
  logic [3:0]  d_sel, cmp_d;
  logic [4:0]  base_addr, rd_addr;
  logic [7:0]  cmp_d1_in;
  logic [31:0] cmp_d4_in;
  logic [79:0] cmp_d10_in;
`ifdef COMPRESS_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int checks = 0;
  int errors = 0;
  compress_ctrl_if ostr ();
  compress_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .d_sel(d_sel), .base_addr(base_addr),
    .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr(rd_addr), .cmp_d(cmp_d),
    .cmp_d1_in(cmp_d1_in), .cmp_d4_in(cmp_d4_in), .cmp_d10_in(cmp_d10_in),
`ifdef COMPRESS_CTRL_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .ostr(ostr)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  d;
    logic [4:0]  base;
    bit          tog;
    bit          poke;
    logic [79:0] pat;
    int          words;
    int          first;
    bit          bad;
  } vec_t;
  vec_t vecs[9];
  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic logic [79:0] outs();
    return {33'b0, busy, done, err, rd_en, rd_addr, cmp_d, ostr.out_valid, ostr.out_data, ostr.out_last};
  endfunction
  // every beat carries the same pattern, so stream bit p is pattern bit p mod beat width
  function automatic logic [31:0] exp_word(input logic [79:0] pat, input int bw, input int i);
    logic [31:0] r;
    for (int j = 0; j < 32; j++) r[j] = pat[(32 * i + j) % bw];
    return r;
  endfunction
  task automatic run_case(input vec_t v);
    int nrd, nw, first, stalls, done_cyc, last_hs, bw;
    bit pv_stall, rdy;
    logic [31:0] pdata;
    logic plast;
    logic [4:0] ea;
    bw = 8 * int'(v.d);
    nrd = 0; nw = 0; first = 0; stalls = 0; done_cyc = 0; last_hs = 0; pv_stall = 0;
    pdata = '0; plast = 0;
    @(negedge clk);
    d_sel = v.d; base_addr = v.base;
    cmp_d1_in = v.pat[7:0]; cmp_d4_in = v.pat[31:0]; cmp_d10_in = v.pat;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (v.bad) begin
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      chk("err_rd_en", rd_en, 0);
      @(negedge clk);
      chk("err_clear", err, 0);
      for (int k = 0; k < 3; k++) begin
        chk("err_idle", {busy, rd_en}, 0);
        @(negedge clk);
      end
      return;
    end
    chk("busy_set", busy, 1);
    for (int k = 1; k < 3000 && done_cyc == 0; k++) begin
      start = v.poke && k == 5;
      d_sel = (v.poke && k == 5) ? 4'd10 : v.d;
      if (rd_en) begin
        ea = v.base + 5'(nrd);
        chk("rd_addr", rd_addr, ea);
        nrd++;
      end
      if (pv_stall) chk("hold_valid", ostr.out_valid, 1);
      if (done) begin
        done_cyc = k;
        chk("done_timing", k, last_hs + 1);
        chk("done_busy", busy, 0);
        chk("done_words", nw, v.words);
      end else begin
        chk("cmp_d", cmp_d, v.d);
        chk("busy_hold", busy, 1);
        if (ostr.out_valid) begin
          if (first == 0) first = k;
          chk("word", ostr.out_data, exp_word(v.pat, bw, nw));
          chk("last", ostr.out_last, nw == v.words - 1);
          if (pv_stall) chk("stable", {ostr.out_data, ostr.out_last}, {pdata, plast});
          rdy = v.tog ? k[0] : 1'b1;
          ostr.out_ready = rdy;
          if (rdy) begin
            if (ostr.out_last) last_hs = k;
            nw++;
          end else stalls++;
          pv_stall = !rdy;
          pdata = ostr.out_data;
          plast = ostr.out_last;
        end else pv_stall = 0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", done_cyc != 0, 1);
    chk("reads", nrd, 32);
    chk("words", nw, v.words);
    chk("first_valid", first, v.first);
`ifdef COMPRESS_CTRL_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stalls);
`endif
    chk("after_done", {done, busy, cmp_d}, 0);
  endtask
  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; d_sel = '0; base_addr = '0;
    cmp_d1_in = '0; cmp_d4_in = '0; cmp_d10_in = '0; ostr.out_ready = 1'b0;
    vecs[0] = '{4'd4,  5'd0,  1'b0, 1'b0, 80'h11111111, 32, 4, 1'b0};
    vecs[1] = '{4'd1,  5'd3,  1'b0, 1'b0, 80'hFF, 8, 7, 1'b0};
    vecs[2] = '{4'd10, 5'd7,  1'b1, 1'b0, 80'h80200802008020080200, 80, 4, 1'b0};
    vecs[3] = '{4'd4,  5'd30, 1'b0, 1'b0, 80'h87654321, 32, 4, 1'b0};
    vecs[4] = '{4'd5,  5'd0,  1'b0, 1'b0, 80'h0, 0, 0, 1'b1};
    vecs[5] = '{4'd10, 5'd0,  1'b0, 1'b0, 80'h0123456789ABCDEF0123, 80, 4, 1'b0};
    vecs[6] = '{4'd1,  5'd31, 1'b1, 1'b0, 80'h5A, 8, 7, 1'b0};
    vecs[7] = '{4'd4,  5'd12, 1'b0, 1'b1, 80'hDEADBEEF, 32, 4, 1'b0};
    vecs[8] = '{4'd0,  5'd0,  1'b0, 1'b0, 80'h0, 0, 0, 1'b1};
    #1 chk("reset_outs", outs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) run_case(vecs[i]);
    @(negedge clk);
    d_sel = 4'd10; base_addr = 5'd0; cmp_d10_in = 80'h80200802008020080200;
    ostr.out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 500 && n < 10; k++) begin
      if (rd_en) n++;
      if (n < 10) @(negedge clk);
    end
    chk("beats_before_rst", n, 10);
    #2 rst_n = 1'b0;
    #1 chk("midrun_rst_outs", outs(), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("no_done_after_rst", {done, busy}, 0);
      @(negedge clk);
    end
    run_case(vecs[5]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
